// File: rtl/timer_pkg.sv
// Shared definitions for the timer peripheral: register map, CTRL bit positions,
// bus handshake states and the byte-lane merge helper.
package timer_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_RELOAD = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_EN        = 0;
    localparam int CTRL_AUTO      = 1;
    localparam int CTRL_IRQ_EN    = 2;
    localparam int STATUS_EXPIRED = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } bus_state_t;

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  be);
        logic [31:0] result;
        result = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) result[8*i +: 8] = new_val[8*i +: 8];
        end
        return result;
    endfunction

endpackage

// File: rtl/timer_responder_if.sv
// CPU-side bus of the timer: strobes, address/data and the acknowledge path back.
interface timer_responder_if;
    logic        AS_L;
    logic        WE_L;
    logic        Timer_Select_H;
    logic [31:0] Address;
    logic [3:0]  Byte_Enable;
    logic [31:0] Data_In;
    logic [31:0] Data_Out;
    logic        DTAck;

    modport master (
        output AS_L, WE_L, Timer_Select_H, Address, Byte_Enable, Data_In,
        input  Data_Out, DTAck
    );

    modport slave (
        input  AS_L, WE_L, Timer_Select_H, Address, Byte_Enable, Data_In,
        output Data_Out, DTAck
    );
endinterface

// File: rtl/bus_responder_fsm.sv
// Generic asynchronous-bus responder: select detection, programmable wait states and
// DTAck handshake, with strobes telling the owning peripheral when to latch and commit.
module bus_responder_fsm
    import timer_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic as_l,
    input  logic sel,
    output logic capture,
    output logic commit,
    output logic done,
    output logic dtack
);

    localparam logic [3:0] LAST_WAIT = 4'(WAIT_STATES - 1);

    bus_state_t state;
    logic [3:0] wait_cnt;

    // commit is high in the cycle whose closing edge enters ACK
    assign capture = (state == IDLE) && !as_l && sel;
    assign commit  = (capture && (WAIT_STATES == 0)) ||
                     ((state == WAIT) && !as_l && (wait_cnt == LAST_WAIT));
    assign done    = (state == ACK) && as_l;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            wait_cnt <= '0;
            dtack    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (capture) begin
                        if (WAIT_STATES == 0) begin
                            state <= ACK;
                            dtack <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (as_l) begin
                        state <= IDLE;
                    end else if (wait_cnt == LAST_WAIT) begin
                        state <= ACK;
                        dtack <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                ACK: begin
                    if (as_l) begin
                        state <= IDLE;
                        dtack <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    dtack <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/timer_responder.sv
// Down-counting timer peripheral with CTRL/RELOAD/COUNT/STATUS registers, a level
// interrupt and a wait-stated DTAck bus handshake.
module timer_responder
    import timer_pkg::*;
#(
    parameter int unsigned WAIT_STATES  = 1,
    parameter logic [31:0] RESET_RELOAD = 32'h0000_0000
) (
    input  logic             Clock,
    input  logic             Reset_L,
    timer_responder_if.slave bus,
    output logic             IRQ_H
);

    logic        capture, commit, done;
    logic [1:0]  lat_addr, txn_addr;
    logic        lat_we_l, txn_we_l;
    logic [3:0]  lat_be, txn_be;
    logic [31:0] lat_data, txn_data;
    logic [2:0]  ctrl;
    logic [31:0] reload, count, count_step, reload_merged, read_mux;
    logic        expired, expire;
    logic        wr_commit, wr_ctrl, wr_reload, clr_expired;
    logic        unused_addr;

    assign unused_addr = ^{bus.Address[31:4], bus.Address[1:0]};

    bus_responder_fsm #(.WAIT_STATES(WAIT_STATES)) u_fsm (
        .clk     (Clock),
        .rst_n   (Reset_L),
        .as_l    (bus.AS_L),
        .sel     (bus.Timer_Select_H),
        .capture (capture),
        .commit  (commit),
        .done    (done),
        .dtack   (bus.DTAck)
    );

    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            lat_addr <= '0;
            lat_we_l <= 1'b1;
            lat_be   <= '0;
            lat_data <= '0;
        end else if (capture) begin
            lat_addr <= bus.Address[3:2];
            lat_we_l <= bus.WE_L;
            lat_be   <= bus.Byte_Enable;
            lat_data <= bus.Data_In;
        end
    end

    // With zero wait states the commit lands on the capture edge, so the live bus is used then
    assign txn_addr = capture ? bus.Address[3:2]  : lat_addr;
    assign txn_we_l = capture ? bus.WE_L          : lat_we_l;
    assign txn_be   = capture ? bus.Byte_Enable   : lat_be;
    assign txn_data = capture ? bus.Data_In       : lat_data;

    assign wr_commit     = commit && !txn_we_l;
    assign wr_ctrl       = wr_commit && (txn_addr == REG_CTRL) && txn_be[0];
    assign wr_reload     = wr_commit && (txn_addr == REG_RELOAD) && (|txn_be);
    assign clr_expired   = wr_commit && (txn_addr == REG_STATUS) && txn_be[0] &&
                           txn_data[STATUS_EXPIRED];
    assign reload_merged = merge_lanes(reload, txn_data, txn_be);
    assign expire        = ctrl[CTRL_EN] && (count == 32'd1);

    always_comb begin
        count_step = count;
        if (ctrl[CTRL_EN]) begin
            if (count > 32'd1) count_step = count - 32'd1;
            else               count_step = ctrl[CTRL_AUTO] ? reload : 32'd0;
        end
    end

    always_comb begin
        read_mux = '0;
        case (txn_addr)
            REG_CTRL:   read_mux = {29'd0, ctrl};
            REG_RELOAD: read_mux = reload;
            REG_COUNT:  read_mux = count;
            REG_STATUS: read_mux = {31'd0, expired};
            default:    read_mux = '0;
        endcase
    end

    // A RELOAD write overrides the count step; a fresh expiry beats a status clear
    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L) begin
            ctrl    <= '0;
            reload  <= RESET_RELOAD;
            count   <= RESET_RELOAD;
            expired <= 1'b0;
            IRQ_H   <= 1'b0;
        end else begin
            if (wr_ctrl) ctrl <= txn_data[2:0];
            if (wr_reload) begin
                reload <= reload_merged;
                count  <= reload_merged;
            end else begin
                count  <= count_step;
            end
            if (expire)           expired <= 1'b1;
            else if (clr_expired) expired <= 1'b0;
            IRQ_H <= expired && ctrl[CTRL_IRQ_EN];
        end
    end

    always_ff @(posedge Clock or negedge Reset_L) begin
        if (!Reset_L)    bus.Data_Out <= '0;
        else if (commit) bus.Data_Out <= txn_we_l ? read_mux : 32'd0;
        else if (done)   bus.Data_Out <= '0;
    end

endmodule

// File: tb/tb_timer_responder.sv
// Randomised and directed bench for timer_responder against a cycle-level model of the
// timer register rules; bus timing is derived from the wait-state count.
module tb_timer_responder;

    localparam int          WS = 2;
    localparam logic [31:0] RR = 32'h0000_0007;

    logic Clock;
    logic Reset_L;
    logic IRQ_H;

    int checks   = 0;
    int failures = 0;

    timer_responder_if bus_if ();

    timer_responder #(.WAIT_STATES(WS), .RESET_RELOAD(RR)) dut (
        .Clock   (Clock),
        .Reset_L (Reset_L),
        .bus     (bus_if),
        .IRQ_H   (IRQ_H)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // Reference model state
    logic [2:0]  m_ctrl;
    logic [31:0] m_reload, m_count;
    logic        m_expired, m_irq;
    bit          pend_wr;
    logic [1:0]  pend_addr;
    logic [3:0]  pend_be;
    logic [31:0] pend_data;

    function automatic void model_reset();
        m_ctrl = 3'd0; m_reload = RR; m_count = RR; m_expired = 1'b0; m_irq = 1'b0;
        pend_wr = 1'b0;
    endfunction

    function automatic void model_step();
        logic [31:0] nc, nr;
        logic [2:0]  nctl;
        logic        ne;
        nc = m_count; nr = m_reload; nctl = m_ctrl; ne = m_expired;
        if (m_ctrl[0]) begin
            if (m_count > 1)    nc = m_count - 1;
            else if (m_ctrl[1]) nc = m_reload;
            else                nc = 0;
        end
        if (pend_wr) begin
            case (pend_addr)
                2'd0: if (pend_be[0]) nctl = pend_data[2:0];
                2'd1: begin
                    for (int i = 0; i < 4; i++)
                        if (pend_be[i]) nr[8*i +: 8] = pend_data[8*i +: 8];
                    if (pend_be != 0) nc = nr;
                end
                2'd3: if (pend_be[0] && pend_data[0]) ne = 1'b0;
                default: ;
            endcase
        end
        if (m_ctrl[0] && m_count == 1) ne = 1'b1;
        m_irq = m_expired && m_ctrl[2];
        m_ctrl = nctl; m_reload = nr; m_count = nc; m_expired = ne;
        pend_wr = 1'b0;
    endfunction

    function automatic logic [31:0] model_read(input logic [1:0] a);
        case (a)
            2'd0:    return {29'd0, m_ctrl};
            2'd1:    return m_reload;
            2'd2:    return m_count;
            default: return {31'd0, m_expired};
        endcase
    endfunction

    task automatic tick();
        @(posedge Clock);
        model_step();
        #1;
    endtask

    // Full bus cycle; reports observed handshake/data, the model's expected read data,
    // and whether DTAck/Data_Out behaved around ACK entry and release.
    task automatic bus_txn(input bit write, input logic [1:0] a, input logic [3:0] be,
                           input logic [31:0] d, output logic [31:0] rdata,
                           output logic [31:0] exp_rdata, output bit ack_ok,
                           output bit release_ok);
        bus_if.AS_L           = 1'b0;
        bus_if.WE_L           = !write;
        bus_if.Timer_Select_H = 1'b1;
        bus_if.Address        = {28'($urandom), a, 2'($urandom)};
        bus_if.Byte_Enable    = be;
        bus_if.Data_In        = d;
        ack_ok    = 1'b1;
        exp_rdata = '0;
        for (int i = 0; i <= WS; i++) begin
            if (i == WS) begin
                exp_rdata = write ? 32'd0 : model_read(a);
                if (write) begin
                    pend_wr = 1'b1; pend_addr = a; pend_be = be; pend_data = d;
                end
            end
            tick();
            if (bus_if.DTAck !== (i == WS)) ack_ok = 1'b0;
            if (i == 0 && WS > 0) begin
                bus_if.Data_In     = $urandom;
                bus_if.Byte_Enable = 4'($urandom);
                bus_if.Address     = $urandom;
                bus_if.WE_L        = 1'($urandom);
            end
        end
        rdata = bus_if.Data_Out;
        tick();
        if (bus_if.DTAck !== 1'b1 || bus_if.Data_Out !== rdata) ack_ok = 1'b0;
        bus_if.AS_L           = 1'b1;
        bus_if.Timer_Select_H = 1'b0;
        tick();
        release_ok = (bus_if.DTAck === 1'b0) && (bus_if.Data_Out === 32'd0);
    endtask

    task automatic test_reset();
        logic [31:0] rd, ex;
        logic [31:0] want [4];
        bit ak, rl;
        want[0] = 32'd0; want[1] = RR; want[2] = RR; want[3] = 32'd0;
        #12;
        checks++;
        if (bus_if.DTAck !== 1'b0 || bus_if.Data_Out !== 32'd0 || IRQ_H !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_outputs got dtack=%0b data=%h irq=%0b want 0/0/0",
                     bus_if.DTAck, bus_if.Data_Out, IRQ_H);
        end
        @(negedge Clock);
        Reset_L = 1'b1;
        for (int a = 0; a < 4; a++) begin
            bus_txn(1'b0, 2'(a), 4'hF, 32'd0, rd, ex, ak, rl);
            checks++;
            if (rd !== want[a] || !ak || !rl) begin
                failures++;
                $display("[TB] FAIL reset_reg%0d got=%h ack=%0b rel=%0b want=%h ack=1 rel=1",
                         a, rd, ak, rl, want[a]);
            end
        end
    endtask

    task automatic test_countdown();
        logic [31:0] rd, ex;
        bit ak, rl;
        bus_txn(1'b1, 2'd1, 4'hF, 32'd5, rd, ex, ak, rl);
        bus_txn(1'b1, 2'd0, 4'hF, 32'd1, rd, ex, ak, rl);
        checks++;
        if (rd !== 32'd0 || !ak || !rl) begin
            failures++;
            $display("[TB] FAIL write_dataout got=%h ack=%0b rel=%0b want=0 ack=1 rel=1", rd, ak, rl);
        end
        // Count is 5 on the CTRL commit edge; this read commits five edges later
        bus_txn(1'b0, 2'd2, 4'hF, 32'd0, rd, ex, ak, rl);
        checks++;
        if (rd !== 32'd1 || ex !== 32'd1) begin
            failures++;
            $display("[TB] FAIL countdown_mid got=%h model=%h want=1", rd, ex);
        end
        bus_txn(1'b0, 2'd2, 4'hF, 32'd0, rd, ex, ak, rl);
        checks++;
        if (rd !== 32'd0) begin
            failures++;
            $display("[TB] FAIL countdown_end got=%h want=0", rd);
        end
        bus_txn(1'b0, 2'd3, 4'hF, 32'd0, rd, ex, ak, rl);
        checks++;
        if (rd !== 32'd1 || IRQ_H !== 1'b0) begin
            failures++;
            $display("[TB] FAIL countdown_status got=%h irq=%0b want status=1 irq=0", rd, IRQ_H);
        end
    endtask

    task automatic test_periodic();
        logic [31:0] rd, ex;
        bit ak, rl, saw_high;
        bus_txn(1'b1, 2'd0, 4'hF, 32'd0, rd, ex, ak, rl);
        bus_txn(1'b1, 2'd3, 4'hF, 32'd1, rd, ex, ak, rl);
        bus_txn(1'b1, 2'd0, 4'hF, 32'd7, rd, ex, ak, rl);
        bus_txn(1'b1, 2'd1, 4'hF, 32'd3, rd, ex, ak, rl);
        saw_high = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (IRQ_H === 1'b1) saw_high = 1'b1;
            checks++;
            if (IRQ_H !== m_irq) begin
                failures++;
                $display("[TB] FAIL periodic_irq cycle %0d got=%0b want=%0b", i, IRQ_H, m_irq);
            end
        end
        checks++;
        if (!saw_high) begin
            failures++;
            $display("[TB] FAIL periodic_irq_seen got=0 want=1");
        end
        bus_txn(1'b1, 2'd0, 4'hF, 32'd4, rd, ex, ak, rl);
        bus_txn(1'b1, 2'd3, 4'h1, 32'd1, rd, ex, ak, rl);
        checks++;
        if (IRQ_H !== 1'b0) begin
            failures++;
            $display("[TB] FAIL irq_clear got=%0b want=0", IRQ_H);
        end
    endtask

    task automatic test_set_wins();
        logic [31:0] rd, ex;
        bit ak, rl;
        bus_txn(1'b1, 2'd0, 4'hF, 32'd3, rd, ex, ak, rl);
        bus_txn(1'b1, 2'd1, 4'hF, 32'd3, rd, ex, ak, rl);
        for (int k = 0; k < 3; k++) begin
            bus_txn(1'b1, 2'd3, 4'hF, 32'd1, rd, ex, ak, rl);
            bus_txn(1'b0, 2'd3, 4'hF, 32'd0, rd, ex, ak, rl);
            checks++;
            if (rd !== ex) begin
                failures++;
                $display("[TB] FAIL set_wins phase %0d got=%h want=%h", k, rd, ex);
            end
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd, ex;
        bit ak, rl;
        bus_txn(1'b1, 2'd0, 4'hF, 32'd0, rd, ex, ak, rl);
        bus_txn(1'b1, 2'd1, 4'hF, 32'd0, rd, ex, ak, rl);
        bus_txn(1'b1, 2'd1, 4'b0010, 32'hFFFF_FFFF, rd, ex, ak, rl);
        bus_txn(1'b0, 2'd1, 4'hF, 32'd0, rd, ex, ak, rl);
        checks++;
        if (rd !== 32'h0000_FF00) begin
            failures++;
            $display("[TB] FAIL lane_reload got=%h want=0000ff00", rd);
        end
        bus_txn(1'b1, 2'd2, 4'hF, 32'h1234, rd, ex, ak, rl);
        bus_txn(1'b0, 2'd2, 4'hF, 32'd0, rd, ex, ak, rl);
        checks++;
        if (rd !== 32'h0000_FF00) begin
            failures++;
            $display("[TB] FAIL count_readonly got=%h want=0000ff00", rd);
        end
        bus_txn(1'b1, 2'd0, 4'b1110, 32'hFF, rd, ex, ak, rl);
        bus_txn(1'b0, 2'd0, 4'hF, 32'd0, rd, ex, ak, rl);
        checks++;
        if (rd !== 32'd0) begin
            failures++;
            $display("[TB] FAIL ctrl_lane0_only got=%h want=0", rd);
        end
    endtask

    task automatic test_abort();
        logic [31:0] rd, ex;
        bit ak, rl, quiet;
        bus_if.AS_L = 1'b0; bus_if.WE_L = 1'b0; bus_if.Timer_Select_H = 1'b1;
        bus_if.Address = 32'h4; bus_if.Byte_Enable = 4'hF; bus_if.Data_In = 32'hDEAD_BEEF;
        quiet = 1'b1;
        tick();
        if (bus_if.DTAck !== 1'b0) quiet = 1'b0;
        bus_if.AS_L = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus_if.DTAck !== 1'b0) quiet = 1'b0;
        end
        bus_if.Timer_Select_H = 1'b0;
        checks++;
        if (!quiet) begin
            failures++;
            $display("[TB] FAIL abort_dtack got=1 want=0");
        end
        bus_txn(1'b0, 2'd1, 4'hF, 32'd0, rd, ex, ak, rl);
        checks++;
        if (rd !== 32'h0000_FF00) begin
            failures++;
            $display("[TB] FAIL abort_nowrite got=%h want=0000ff00", rd);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] rd, ex;
        bit ak, rl;
        bus_if.AS_L = 1'b0; bus_if.WE_L = 1'b0; bus_if.Timer_Select_H = 1'b1;
        bus_if.Address = 32'h4; bus_if.Byte_Enable = 4'hF; bus_if.Data_In = 32'hA5A5_A5A5;
        tick();
        #2 Reset_L = 1'b0;
        model_reset();
        bus_if.AS_L = 1'b1; bus_if.Timer_Select_H = 1'b0;
        #2 Reset_L = 1'b1;
        for (int i = 0; i < WS + 2; i++) tick();
        bus_txn(1'b0, 2'd1, 4'hF, 32'd0, rd, ex, ak, rl);
        checks++;
        if (rd !== RR) begin
            failures++;
            $display("[TB] FAIL reset_wait_nowrite got=%h want=%h", rd, RR);
        end
    endtask

    task automatic test_reset_in_ack();
        logic [31:0] rd, ex;
        bit ak, rl;
        bus_txn(1'b1, 2'd1, 4'hF, 32'd2, rd, ex, ak, rl);
        bus_txn(1'b1, 2'd0, 4'hF, 32'd7, rd, ex, ak, rl);
        bus_if.AS_L = 1'b0; bus_if.WE_L = 1'b1; bus_if.Timer_Select_H = 1'b1;
        bus_if.Address = 32'h4; bus_if.Byte_Enable = 4'hF;
        for (int i = 0; i <= WS; i++) tick();
        checks++;
        if (bus_if.DTAck !== 1'b1 || bus_if.Data_Out !== 32'd2) begin
            failures++;
            $display("[TB] FAIL pre_reset_ack got dtack=%0b data=%h want 1/2", bus_if.DTAck, bus_if.Data_Out);
        end
        #2 Reset_L = 1'b0;
        model_reset();
        #1;
        checks++;
        if (bus_if.DTAck !== 1'b0 || bus_if.Data_Out !== 32'd0 || IRQ_H !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_in_ack got dtack=%0b data=%h irq=%0b want 0/0/0",
                     bus_if.DTAck, bus_if.Data_Out, IRQ_H);
        end
        #2 Reset_L = 1'b1;
        // AS_L is still low, so the responder must start a fresh read of RELOAD
        ak = 1'b1;
        for (int i = 0; i <= WS; i++) begin
            tick();
            if (bus_if.DTAck !== (i == WS)) ak = 1'b0;
        end
        checks++;
        if (!ak || bus_if.Data_Out !== RR) begin
            failures++;
            $display("[TB] FAIL restart_after_reset got ack_ok=%0b data=%h want 1/%h", ak, bus_if.Data_Out, RR);
        end
        bus_if.AS_L = 1'b1; bus_if.Timer_Select_H = 1'b0;
        tick();
        for (int a = 0; a < 4; a++) begin
            bus_txn(1'b0, 2'(a), 4'hF, 32'd0, rd, ex, ak, rl);
            checks++;
            if (rd !== ex) begin
                failures++;
                $display("[TB] FAIL post_reset_reg%0d got=%h want=%h", a, rd, ex);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, ex, d;
        logic [1:0]  a;
        logic [3:0]  be;
        bit ak, rl, wr;
        for (int n = 0; n < 40; n++) begin
            a  = 2'($urandom_range(0, 3));
            wr = 1'($urandom_range(0, 1));
            be = 4'($urandom);
            d  = (a == 2'd1) ? 32'($urandom_range(0, 6)) : $urandom;
            bus_txn(wr, a, be, d, rd, ex, ak, rl);
            checks++;
            if (rd !== ex || !ak || !rl) begin
                failures++;
                $display("[TB] FAIL rand_txn %0d addr=%0d wr=%0b got=%h ack=%0b rel=%0b want=%h ack=1 rel=1",
                         n, a, wr, rd, ak, rl, ex);
            end
            for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
                tick();
                checks++;
                if (IRQ_H !== m_irq) begin
                    failures++;
                    $display("[TB] FAIL rand_irq %0d got=%0b want=%0b", n, IRQ_H, m_irq);
                end
            end
        end
    endtask

    initial begin
        Reset_L               = 1'b0;
        bus_if.AS_L           = 1'b1;
        bus_if.WE_L           = 1'b1;
        bus_if.Timer_Select_H = 1'b0;
        bus_if.Address        = '0;
        bus_if.Byte_Enable    = '0;
        bus_if.Data_In        = '0;
        model_reset();
        test_reset();
        test_countdown();
        test_periodic();
        test_set_wins();
        test_byte_lanes();
        test_abort();
        test_reset_mid_wait();
        test_reset_in_ack();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog timeout got=running want=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
